// File: rtl/cam_capture_pkg.sv
// Shared camera/VGA constants: capture geometry, capture FSM encodings, VGA timing.
package cam_capture_pkg;

    localparam int H_PIX_DEF   = 640;
    localparam int V_LINES_DEF = 480;

    localparam logic [1:0] ST_WAIT_VS   = 2'd0;
    localparam logic [1:0] ST_WAIT_HREF = 2'd1;
    localparam logic [1:0] ST_BYTE_HI   = 2'd2;
    localparam logic [1:0] ST_BYTE_LO   = 2'd3;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = 800;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_TOTAL   = 525;

    // Two-line buffer address: line parity selects the half, pixel index within it.
    function automatic logic [10:0] buf_addr(input logic odd, input logic [9:0] idx);
        return {odd, idx};
    endfunction

endpackage

// File: rtl/cam_sync.sv
// Two-flop synchronizer with a third register for rise/fall detection.
module cam_sync #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_sync,
    output logic [W-1:0] o_rise,
    output logic [W-1:0] o_fall
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;
    logic [W-1:0] r_s3;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_sync = r_s2;
    assign o_rise = r_s2 & ~r_s3;
    assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/cam_capture.sv
// Camera capture: oversamples PCLK/HREF/VSYNC on CLK and assembles RGB565 pixels
// into write strobes for a two-line buffer.
module cam_capture
    import cam_capture_pkg::*;
#(
    parameter int H_PIX   = H_PIX_DEF,
    parameter int V_LINES = V_LINES_DEF
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CamPclk,
    input  logic        CamHref,
    input  logic        CamVsync,
    input  logic [7:0]  CamData,
    output logic        CamHsync_EDGE,
    output logic        CamVsync_EDGE,
    output logic        PixWrEn,
    output logic [10:0] PixWrAddr,
    output logic [15:0] PixWrData,
    output logic [8:0]  CamLineCount,
    output logic        OddLine,
    output logic        OvfErr,
    output logic [1:0]  o_dbg_state
);

    localparam logic [10:0] PIX_MAX   = 11'(H_PIX);
    localparam logic [8:0]  LAST_LINE = 9'(V_LINES - 1);

    // Control bit order: [0] PCLK, [1] HREF, [2] VSYNC.
    logic [2:0] w_ctl_sync;
    logic [2:0] w_ctl_rise;
    logic [2:0] w_ctl_fall;
    logic [7:0] w_byte;
    logic [7:0] w_data_rise;
    logic [7:0] w_data_fall;
    logic       w_unused_ctl;
    logic       w_unused_data;

    cam_sync #(.W(3)) u_sync_ctl (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_d     ({CamVsync, CamHref, CamPclk}),
        .o_sync  (w_ctl_sync),
        .o_rise  (w_ctl_rise),
        .o_fall  (w_ctl_fall)
    );

    cam_sync #(.W(8)) u_sync_data (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_d     (CamData),
        .o_sync  (w_byte),
        .o_rise  (w_data_rise),
        .o_fall  (w_data_fall)
    );

    logic w_pclk_rise;
    logic w_href;
    logic w_href_rise;
    logic w_href_fall;
    logic w_vsync_rise;

    assign w_pclk_rise   = w_ctl_rise[0];
    assign w_href        = w_ctl_sync[1];
    assign w_href_rise   = w_ctl_rise[1];
    assign w_href_fall   = w_ctl_fall[1];
    assign w_vsync_rise  = w_ctl_rise[2];
    assign w_unused_ctl  = ^{w_ctl_sync[0], w_ctl_sync[2], w_ctl_fall[0], w_ctl_fall[2]};
    assign w_unused_data = ^{w_data_rise, w_data_fall};

    logic [1:0]  r_state;
    logic        r_hs_edge;
    logic        r_vs_edge;
    logic        r_wr_en;
    logic [10:0] r_wr_addr;
    logic [15:0] r_wr_data;
    logic [8:0]  r_line_cnt;
    logic        r_odd;
    logic        r_ovf;
    logic [10:0] r_pix_idx;
    logic        r_line_sat;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= ST_WAIT_VS;
            r_hs_edge  <= 1'b0;
            r_vs_edge  <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_line_cnt <= '0;
            r_odd      <= 1'b0;
            r_ovf      <= 1'b0;
            r_pix_idx  <= '0;
            r_line_sat <= 1'b0;
        end else begin
            r_hs_edge <= w_href_rise;
            r_vs_edge <= w_vsync_rise;
            r_wr_en   <= 1'b0;

            // Frame start wins over everything, dropping any half-assembled pixel.
            if (r_vs_edge) begin
                r_state    <= ST_WAIT_HREF;
                r_line_cnt <= '0;
                r_odd      <= 1'b0;
                r_pix_idx  <= '0;
                r_ovf      <= 1'b0;
                r_line_sat <= 1'b0;
            end else begin
                case (r_state)
                    ST_WAIT_VS: begin
                        r_state <= ST_WAIT_VS;
                    end
                    ST_WAIT_HREF: begin
                        if (w_href) begin
                            r_state   <= ST_BYTE_HI;
                            r_pix_idx <= '0;
                            if (r_line_sat) begin
                                r_ovf <= 1'b1;
                            end
                        end
                    end
                    ST_BYTE_HI, ST_BYTE_LO: begin
                        // Line end outranks a coincident PCLK edge; that byte is lost.
                        if (w_href_fall) begin
                            r_state <= ST_WAIT_HREF;
                            r_odd   <= ~r_odd;
                            if (r_line_cnt == LAST_LINE) begin
                                r_line_sat <= 1'b1;
                            end else begin
                                r_line_cnt <= r_line_cnt + 9'd1;
                            end
                        end else if (w_pclk_rise && w_href) begin
                            if (r_state == ST_BYTE_HI) begin
                                r_wr_data[15:8] <= w_byte;
                                r_state         <= ST_BYTE_LO;
                            end else begin
                                r_state <= ST_BYTE_HI;
                                if (r_pix_idx == PIX_MAX) begin
                                    r_ovf <= 1'b1;
                                end else begin
                                    r_wr_data[7:0] <= w_byte;
                                    r_wr_en        <= 1'b1;
                                    r_wr_addr      <= buf_addr(r_odd, r_pix_idx[9:0]);
                                    r_pix_idx      <= r_pix_idx + 11'd1;
                                end
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_WAIT_VS;
                    end
                endcase
            end
        end
    end

    assign CamHsync_EDGE = r_hs_edge;
    assign CamVsync_EDGE = r_vs_edge;
    assign PixWrEn       = r_wr_en;
    assign PixWrAddr     = r_wr_addr;
    assign PixWrData     = r_wr_data;
    assign CamLineCount  = r_line_cnt;
    assign OddLine       = r_odd;
    assign OvfErr        = r_ovf;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture: expected pixel writes queued at stimulus time,
// compared as strobes appear; status checks after each scenario.
module tb_cam_capture;
  import cam_capture_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CamPclk = 1'b0;
  logic        CamHref = 1'b0;
  logic        CamVsync = 1'b0;
  logic [7:0]  CamData = 8'h00;
  logic        CamHsync_EDGE;
  logic        CamVsync_EDGE;
  logic        PixWrEn;
  logic [10:0] PixWrAddr;
  logic [15:0] PixWrData;
  logic [8:0]  CamLineCount;
  logic        OddLine;
  logic        OvfErr;
  logic [1:0]  o_dbg_state;

  int tests_run = 0;
  int fail_cnt = 0;
  int wr_cnt = 0;
  int vs_cnt = 0;
  int hs_cnt = 0;
  int base = 0;
  logic [10:0] last_addr = '0;
  logic [26:0] exp_q[$];

  cam_capture #(.H_PIX(640), .V_LINES(4)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .CamPclk       (CamPclk),
    .CamHref       (CamHref),
    .CamVsync      (CamVsync),
    .CamData       (CamData),
    .CamHsync_EDGE (CamHsync_EDGE),
    .CamVsync_EDGE (CamVsync_EDGE),
    .PixWrEn       (PixWrEn),
    .PixWrAddr     (PixWrAddr),
    .PixWrData     (PixWrData),
    .CamLineCount  (CamLineCount),
    .OddLine       (OddLine),
    .OvfErr        (OvfErr),
    .o_dbg_state   (o_dbg_state)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge CLK) begin
    if (CamVsync_EDGE) vs_cnt++;
    if (CamHsync_EDGE) hs_cnt++;
    if (PixWrEn) begin
      wr_cnt++;
      last_addr = PixWrAddr;
      chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("wr_addr_data", {5'b0, PixWrAddr, PixWrData}, {5'b0, exp_q.pop_front()});
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b);
    CamData = b;
    tick(2);
    CamPclk = 1'b1;
    tick(4);
    CamPclk = 1'b0;
    tick(2);
  endtask

  task automatic send_pixel(input logic [15:0] px, input logic [10:0] addr, input bit wr);
    if (wr) exp_q.push_back({addr, px});
    send_byte(px[15:8]);
    send_byte(px[7:0]);
  endtask

  task automatic line_start();
    CamHref = 1'b1;
    tick(4);
  endtask

  task automatic line_end();
    CamHref = 1'b0;
    tick(6);
  endtask

  task automatic vsync_pulse();
    CamVsync = 1'b1;
    tick(10);
    CamVsync = 1'b0;
    tick(6);
  endtask

  initial begin
    // reset state
    tick(3);
    chk("rst_wr_en", 32'(PixWrEn), 32'd0);
    chk("rst_wr_addr", 32'(PixWrAddr), 32'd0);
    chk("rst_wr_data", 32'(PixWrData), 32'd0);
    chk("rst_line_cnt", 32'(CamLineCount), 32'd0);
    chk("rst_odd", 32'(OddLine), 32'd0);
    chk("rst_ovf", 32'(OvfErr), 32'd0);
    chk("rst_hs_edge", 32'(CamHsync_EDGE), 32'd0);
    chk("rst_vs_edge", 32'(CamVsync_EDGE), 32'd0);
    chk("rst_state", 32'(o_dbg_state), 32'(ST_WAIT_VS));
    RST_N = 1'b1;
    tick(4);

    // vsync edge timing: pulse lands three CLKs after the raw rise
    CamVsync = 1'b1;
    tick(2);
    chk("vs_edge_early", 32'(CamVsync_EDGE), 32'd0);
    tick(1);
    chk("vs_edge_at3", 32'(CamVsync_EDGE), 32'd1);
    tick(1);
    chk("vs_edge_after", 32'(CamVsync_EDGE), 32'd0);
    chk("vs_state", 32'(o_dbg_state), 32'(ST_WAIT_HREF));
    chk("vs_line_cnt", 32'(CamLineCount), 32'd0);
    tick(6);
    CamVsync = 1'b0;
    tick(6);
    chk("vs_pulse_count", 32'(vs_cnt), 32'd1);

    // four-pixel line
    base = wr_cnt;
    line_start();
    send_pixel(16'h1234, 11'd0, 1'b1);
    send_pixel(16'h5678, 11'd1, 1'b1);
    send_pixel(16'h9ABC, 11'd2, 1'b1);
    send_pixel(16'hDEF0, 11'd3, 1'b1);
    line_end();
    chk("l1_writes", 32'(wr_cnt - base), 32'd4);
    chk("l1_last_addr", 32'(last_addr), 32'd3);
    chk("l1_line_cnt", 32'(CamLineCount), 32'd1);
    chk("l1_odd", 32'(OddLine), 32'd1);
    chk("l1_hs_count", 32'(hs_cnt), 32'd1);
    chk("l1_ovf", 32'(OvfErr), 32'd0);

    // seven bytes on an odd line: dangling byte dropped
    base = wr_cnt;
    line_start();
    send_pixel(16'hA1B2, 11'h400, 1'b1);
    send_pixel(16'hC3D4, 11'h401, 1'b1);
    send_pixel(16'hE5F6, 11'h402, 1'b1);
    send_byte(8'h77);
    line_end();
    chk("odd_writes", 32'(wr_cnt - base), 32'd3);
    chk("odd_last_addr", 32'(last_addr), 32'h402);
    chk("odd_line_cnt", 32'(CamLineCount), 32'd2);
    chk("odd_parity", 32'(OddLine), 32'd0);
    chk("odd_q_empty", 32'(exp_q.size()), 32'd0);

    // vsync while the low byte is pending
    base = wr_cnt;
    line_start();
    send_byte(8'h55);
    chk("mid_state_lo", 32'(o_dbg_state), 32'(ST_BYTE_LO));
    CamHref = 1'b0;
    CamVsync = 1'b1;
    tick(10);
    CamVsync = 1'b0;
    tick(6);
    chk("mid_writes", 32'(wr_cnt - base), 32'd0);
    chk("mid_line_cnt", 32'(CamLineCount), 32'd0);
    chk("mid_odd", 32'(OddLine), 32'd0);
    chk("mid_state", 32'(o_dbg_state), 32'(ST_WAIT_HREF));
    base = wr_cnt;
    line_start();
    send_pixel(16'h0102, 11'd0, 1'b1);
    send_pixel(16'h0304, 11'd1, 1'b1);
    line_end();
    chk("mid_next_writes", 32'(wr_cnt - base), 32'd2);
    chk("mid_next_last", 32'(last_addr), 32'd1);
    chk("mid_next_cnt", 32'(CamLineCount), 32'd1);

    // 641-pixel line: index saturates at H_PIX
    vsync_pulse();
    base = wr_cnt;
    line_start();
    for (int i = 0; i < 640; i++) send_pixel(16'(i * 3 + 7), 11'(i), 1'b1);
    chk("ovf_before", 32'(OvfErr), 32'd0);
    send_pixel(16'hFFFF, 11'd0, 1'b0);
    chk("ovf_set", 32'(OvfErr), 32'd1);
    line_end();
    chk("ovf_writes", 32'(wr_cnt - base), 32'd640);
    chk("ovf_last_addr", 32'(last_addr), 32'd639);
    line_start();
    send_pixel(16'h4242, 11'h400, 1'b1);
    line_end();
    chk("ovf_sticky", 32'(OvfErr), 32'd1);
    chk("ovf_next_addr", 32'(last_addr), 32'h400);
    vsync_pulse();
    chk("ovf_cleared", 32'(OvfErr), 32'd0);

    // line counter saturation with V_LINES = 4
    for (int i = 0; i < 4; i++) begin
      line_start();
      line_end();
    end
    chk("lsat_cnt", 32'(CamLineCount), 32'd3);
    chk("lsat_no_ovf", 32'(OvfErr), 32'd0);
    line_start();
    chk("lsat_ovf", 32'(OvfErr), 32'd1);
    line_end();
    chk("lsat_cnt_hold", 32'(CamLineCount), 32'd3);
    vsync_pulse();
    chk("lsat_clr_ovf", 32'(OvfErr), 32'd0);
    chk("lsat_clr_cnt", 32'(CamLineCount), 32'd0);

    // asynchronous reset mid-line, then a line with no vsync
    line_start();
    send_pixel(16'hBEEF, 11'd0, 1'b1);
    line_end();
    line_start();
    send_pixel(16'hCAFE, 11'h400, 1'b1);
    send_byte(8'h99);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_wr_data", 32'(PixWrData), 32'd0);
    chk("arst_wr_addr", 32'(PixWrAddr), 32'd0);
    chk("arst_line_cnt", 32'(CamLineCount), 32'd0);
    chk("arst_odd", 32'(OddLine), 32'd0);
    chk("arst_state", 32'(o_dbg_state), 32'(ST_WAIT_VS));
    tick(3);
    RST_N = 1'b1;
    base = wr_cnt;
    send_pixel(16'h1111, 11'd0, 1'b0);
    send_pixel(16'h1111, 11'd0, 1'b0);
    line_end();
    line_start();
    send_pixel(16'h2222, 11'd0, 1'b0);
    line_end();
    chk("post_rst_writes", 32'(wr_cnt - base), 32'd0);
    chk("post_rst_state", 32'(o_dbg_state), 32'(ST_WAIT_VS));
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    // report
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
